wb_host_initiator: RTL and testbench

Wishbone classic-cycle initiator. It drives the user-area Wishbone slave port (stb/cyc/we/sel/dat/adr out, ack/dat in) from a simple valid/ready command channel. It returns each result on a valid/ready response channel. It is used by on-chip bring-up logic and by testbenches to reach user-project registers. It issues one transaction at a time, enforces a bus timeout, and reports errors.

---
 rtl/wb_host_initiator_if.sv | 37 +++
 rtl/wb_host_initiator.sv | 114 +++++++++++
 tb/tb_wb_host_initiator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/wb_host_initiator_if.sv
// wb_host_initiator_if: command/response channels plus Wishbone master signals for wb_host_initiator.
interface wb_host_initiator_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [DAT_W-1:0] cmd_dat;
    logic [SEL_W-1:0] cmd_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic             wbm_ack_i;
    logic [DAT_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_host_initiator.sv
// wb_host_initiator: single-outstanding Wishbone classic initiator with bus timeout,
// fed by a valid/ready command channel and returning a valid/ready response.
module wb_host_initiator #(
    parameter int             ADR_W    = 32,
    parameter int             DAT_W    = 32,
    parameter int             TIMEOUT  = 255,
    parameter logic [DAT_W-1:0] ERR_DATA = DAT_W'(32'hFFFF_FFFF)
) (
    input logic                 wb_clk_i,
    input logic                 wb_rstn_i,
    wb_host_initiator_if.master bus
);
    localparam int SEL_W = DAT_W / 8;
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             expire;

    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                state_d = BUS;
                cyc_d   = 1'b1;
                we_d    = bus.cmd_we;
                sel_d   = bus.cmd_sel;
                adr_d   = bus.cmd_adr;
                dat_d   = bus.cmd_dat;
                cnt_d   = '0;
            end
            BUS: if (bus.wbm_ack_i || expire) begin
                // ack takes priority over a timeout expiring on the same edge
                state_d     = RESP;
                cyc_d       = 1'b0;
                we_d        = 1'b0;
                sel_d       = '0;
                adr_d       = '0;
                dat_d       = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = !bus.wbm_ack_i;
                rsp_dat_d   = !bus.wbm_ack_i ? ERR_DATA : (we_q ? '0 : bus.wbm_dat_i);
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // cmd_ready is gated by reset so it reads 0 while reset is held
    assign bus.cmd_ready = wb_rstn_i && (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
endmodule

// File: tb/tb_wb_host_initiator.sv
// tb_wb_host_initiator: table-driven transactions plus hand-written backpressure and async-reset sequences.
module tb_wb_host_initiator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    wb_host_initiator_if #(.ADR_W(32), .DAT_W(32)) bus ();

    wb_host_initiator #(
        .ADR_W(32), .DAT_W(32), .TIMEOUT(8), .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i (clk),
        .wb_rstn_i(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        int          bp;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_stb;
    } vec_t;

    vec_t v[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run(input vec_t t);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = t.we;
        bus.cmd_adr   = t.adr;
        bus.cmd_dat   = t.dat;
        bus.cmd_sel   = t.sel;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = $urandom;
        bus.cmd_dat   = $urandom;
        bus.cmd_we    = ~t.we;
        chk("bus_we", bus.wbm_we_o, t.we);
        chk("bus_sel", bus.wbm_sel_o, t.sel);
        chk("bus_dat", bus.wbm_dat_o, t.dat);
        n = 0;
        while (bus.wbm_stb_o === 1'b1 && n < 40) begin
            n++;
            chk("bus_cyc", bus.wbm_cyc_o, 1);
            chk("bus_adr", bus.wbm_adr_o, t.adr);
            chk("cmd_ready_bus", bus.cmd_ready, 0);
            bus.wbm_ack_i = (t.waits >= 0) && (n == t.waits + 1);
            bus.wbm_dat_i = bus.wbm_ack_i ? t.rdata : $urandom;
            @(posedge clk); #1;
            bus.wbm_ack_i = 1'b0;
        end
        chk("stb_cycles", n, t.exp_stb);
        chk("cyc_after", bus.wbm_cyc_o, 0);
        chk("adr_after", bus.wbm_adr_o, 0);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_dat", bus.rsp_dat, t.exp_dat);
        chk("rsp_err", bus.rsp_err, t.exp_err);
        chk("cmd_ready_resp", bus.cmd_ready, 0);
        for (int i = 0; i < t.bp; i++) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = $urandom;
            @(posedge clk); #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_dat", bus.rsp_dat, t.exp_dat);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_stb", bus.wbm_stb_o, 0);
        end
        bus.wbm_ack_i = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_done", bus.rsp_valid, 0);
        chk("cmd_ready_again", bus.cmd_ready, 1);
        chk("rsp_dat_held", bus.rsp_dat, t.exp_dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF,  0, 32'h0,         0, 32'h0,         1'b0, 1};
        v[1] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF,  3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 4};
        v[2] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, -1, 32'h0,         0, 32'hFFFF_FFFF, 1'b1, 8};
        v[3] = '{1'b1, 32'h3000_0024, 32'h00C0_FFEE, 4'h3,  1, 32'h0,         0, 32'h0,         1'b0, 2};
        v[4] = '{1'b0, 32'h3000_0028, 32'h0,         4'hF,  7, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 8};
        v[5] = '{1'b1, 32'h3000_002C, 32'h55AA_55AA, 4'hC,  6, 32'h0,         0, 32'h0,         1'b0, 7};
        v[6] = '{1'b0, 32'h3000_0030, 32'h0,         4'hF,  0, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1'b0, 1};
        v[7] = '{1'b1, 32'h3000_0034, 32'h1111_1111, 4'h1, -1, 32'h0,         2, 32'hFFFF_FFFF, 1'b1, 8};
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
        #1;
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_stb", bus.wbm_stb_o, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_dat", bus.rsp_dat, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("ready_after_rst", bus.cmd_ready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) run(v[i]);
        // async reset in the middle of a bus cycle, away from any clock edge
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h3000_0040;
        bus.cmd_sel   = 4'hF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("ar_stb_before", bus.wbm_stb_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cyc", bus.wbm_cyc_o, 0);
        chk("ar_stb", bus.wbm_stb_o, 0);
        chk("ar_rsp_valid", bus.rsp_valid, 0);
        chk("ar_adr", bus.wbm_adr_o, 0);
        chk("ar_cmd_ready", bus.cmd_ready, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_ready_after", bus.cmd_ready, 1);
        chk("ar_cyc_after", bus.wbm_cyc_o, 0);
        for (int i = 0; i < 3; i++) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = $urandom;
            @(posedge clk); #1;
            chk("ar_no_rsp", bus.rsp_valid, 0);
            chk("ar_stray_ready", bus.cmd_ready, 1);
        end
        bus.wbm_ack_i = 1'b0;
        run(v[1]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
